// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Holds the FSM state encoding, default widths and an index-width helper.
package reg_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    WRITE = 2'b10
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above i_ptr,
// wrapping to 0. Ports: i_req, i_ptr -> o_gnt (one-hot), o_valid.
module rr_priority_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_valid
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    // pass 1: requesters at or above the pointer
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
        o_gnt[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
    // pass 2: wrap around to the low requesters
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_req[j]) begin
        o_gnt[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter serialising N_REQ register-file write requests.
// Ports: CLK, RST (async high), REQ/REQ_ADDR/REQ_DATA in; GNT, ACK, WE,
// W_ADDR, W_DATA out. Optional LOCK input under REG_WRITE_ARB_LOCK_EN.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_REQ-1:0]            REQ,
  input  logic [N_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [N_REQ-1:0]            GNT,
  output logic [N_REQ-1:0]            ACK,
  output logic                        WE,
  output logic [ADDR_WIDTH-1:0]       W_ADDR,
  output logic [DATA_WIDTH-1:0]       W_DATA
`ifdef REG_WRITE_ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]            LOCK
`endif
);

  localparam int IW = idx_w(N_REQ);

  state_t                r_state;
  logic [IW-1:0]         r_ptr;
  logic [N_REQ-1:0]      r_gnt;
  logic [N_REQ-1:0]      r_ack;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [N_REQ-1:0]      w_pick;
  logic                  w_valid;
  logic [N_REQ-1:0]      w_src;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [IW-1:0]         w_win_idx;
  logic [IW-1:0]         w_ptr_nxt;
  logic                  w_relock;

  rr_priority_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick),
    .o_valid (w_valid)
  );

  // Capture source: fresh pick in IDLE, current winner on a locked re-grant.
  always_comb begin
    w_src      = (r_state == IDLE) ? w_pick : r_gnt;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_win_idx  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_src[j]) begin
        w_sel_addr = REQ_ADDR[j*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = REQ_DATA[j*DATA_WIDTH +: DATA_WIDTH];
      end
      if (r_gnt[j]) w_win_idx = IW'(j);
    end
    w_ptr_nxt = (w_win_idx == IW'(N_REQ - 1)) ? '0 : w_win_idx + IW'(1);
  end

`ifdef REG_WRITE_ARB_LOCK_EN
  assign w_relock = |(LOCK & REQ & r_gnt);
`else
  assign w_relock = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= GRANT;
            r_gnt   <= w_pick;
            r_addr  <= w_sel_addr;
            r_data  <= w_sel_data;
          end
        end
        GRANT: begin
          r_state <= WRITE;
          // register 0 is hard-wired: complete the handshake, skip the write
          r_we    <= |r_addr;
          r_ack   <= r_gnt;
          r_waddr <= r_addr;
          r_wdata <= r_data;
        end
        WRITE: begin
          r_we  <= 1'b0;
          r_ack <= '0;
          if (w_relock) begin
            r_state <= GRANT;
            r_addr  <= w_sel_addr;
            r_data  <= w_sel_data;
          end else begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= w_ptr_nxt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_ack   <= '0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign GNT    = r_gnt;
  assign ACK    = r_ack;
  assign WE     = r_we;
  assign W_ADDR = r_waddr;
  assign W_DATA = r_wdata;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed table, corner
// sequences and randomized traffic against a transfer-level model.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            CLK;
  logic            RST;
  logic [N-1:0]    REQ;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    GNT;
  logic [N-1:0]    ACK;
  logic            WE;
  logic [AW-1:0]   W_ADDR;
  logic [DW-1:0]   W_DATA;
`ifdef REG_WRITE_ARB_LOCK_EN
  logic [N-1:0]    LOCK;
`endif

  reg_write_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .REQ_ADDR (REQ_ADDR),
    .REQ_DATA (REQ_DATA),
    .GNT      (GNT),
    .ACK      (ACK),
    .WE       (WE),
    .W_ADDR   (W_ADDR),
    .W_DATA   (W_DATA)
`ifdef REG_WRITE_ARB_LOCK_EN
    ,
    .LOCK     (LOCK)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // transfer-level model: which requester is in flight and how far along
  int            m_ptr;
  int            m_win;
  int            m_age;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_win = -1;
    m_age = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic model_capture(input int who);
    m_addr = REQ_ADDR[who*AW +: AW];
    m_data = REQ_DATA[who*DW +: DW];
  endtask

  task automatic model_edge();
    if (m_win < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_win < 0 && REQ[idx]) begin
          m_win = idx;
          m_age = 1;
          model_capture(idx);
        end
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else begin
`ifdef REG_WRITE_ARB_LOCK_EN
      if (LOCK[m_win] && REQ[m_win]) begin
        m_age = 1;
        model_capture(m_win);
      end else begin
        m_ptr = (m_win + 1) % N;
        m_win = -1;
        m_age = 0;
      end
`else
      m_ptr = (m_win + 1) % N;
      m_win = -1;
      m_age = 0;
`endif
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_gnt;
    e_gnt = '0;
    if (m_win >= 0) e_gnt[m_win] = 1'b1;
    chk("gnt", GNT, e_gnt);
    chk("ack", ACK, (m_age == 2) ? e_gnt : '0);
    chk("we", WE, (m_age == 2) && (m_addr != '0));
    chk("ack_onehot0", $onehot0(ACK), 1);
    if (m_age == 2) begin
      chk("w_addr", W_ADDR, m_addr);
      chk("w_data", W_DATA, m_data);
    end
  endtask

  int cyc = 0;

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare();
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_gnt", GNT, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_we", WE, 0);
    chk("rst_waddr", W_ADDR, 0);
    chk("rst_wdata", W_DATA, 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic int ack_idx(input logic [N-1:0] a);
    int r;
    r = -1;
    for (int j = 0; j < N; j++) if (a[j]) r = j;
    return r;
  endfunction

  typedef struct {
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    gnt;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int q_idx[$];
    int q_cyc[$];
    RST = 1'b1;
    REQ = '0;
    REQ_ADDR = '0;
    REQ_DATA = '0;
`ifdef REG_WRITE_ARB_LOCK_EN
    LOCK = '0;
`endif
    model_reset();

    tbl[0] = '{4'b0010, {5'd0, 5'd0, 5'd3, 5'd0},
               {32'h0, 32'h0, 32'hA5A5_0001, 32'h0},
               4'b0010, 1'b1, 5'd3, 32'hA5A5_0001};
    tbl[1] = '{4'b0100, {5'd4, 5'd0, 5'd9, 5'd1},
               {32'h33, 32'hCAFE_0002, 32'h11, 32'h0},
               4'b0100, 1'b0, 5'd0, 32'hCAFE_0002};
    tbl[2] = '{4'b1100, {5'd20, 5'd12, 5'd1, 5'd1},
               {32'hDDDD_0003, 32'hCCCC_0002, 32'h1, 32'h0},
               4'b0100, 1'b1, 5'd12, 32'hCCCC_0002};
    tbl[3] = '{4'b1001, {5'd30, 5'd2, 5'd2, 5'd17},
               {32'h3, 32'h2, 32'h1, 32'h1111_0000},
               4'b0001, 1'b1, 5'd17, 32'h1111_0000};
    tbl[4] = '{4'b1000, {5'd31, 5'd1, 5'd1, 5'd1},
               {32'hFFFF_FFFF, 32'h2, 32'h1, 32'h0},
               4'b1000, 1'b1, 5'd31, 32'hFFFF_FFFF};

    // directed single transfers, each from a fresh reset
    for (int i = 0; i < 5; i++) begin
      do_reset();
      REQ = tbl[i].req;
      REQ_ADDR = tbl[i].addr;
      REQ_DATA = tbl[i].data;
      step();
      chk("vec_gnt1", GNT, tbl[i].gnt);
      chk("vec_we1", WE, 0);
      REQ = '0;
      step();
      chk("vec_gnt2", GNT, tbl[i].gnt);
      chk("vec_ack2", ACK, tbl[i].gnt);
      chk("vec_we2", WE, tbl[i].we);
      chk("vec_waddr", W_ADDR, tbl[i].waddr);
      chk("vec_wdata", W_DATA, tbl[i].wdata);
      step();
      chk("vec_gnt3", GNT, 0);
      chk("vec_ack3", ACK, 0);
      chk("vec_we3", WE, 0);
    end

    // all four held from reset: order 0,1,2,3,0 spaced 3 cycles apart
    do_reset();
    REQ = 4'b1111;
    REQ_ADDR = {5'd4, 5'd3, 5'd2, 5'd1};
    REQ_DATA = {32'h4, 32'h3, 32'h2, 32'h1};
    for (int c = 0; c < 15; c++) begin
      step();
      if (ACK != '0) begin
        q_idx.push_back(ack_idx(ACK));
        q_cyc.push_back(c);
      end
    end
    chk("rr_count", q_idx.size(), 5);
    for (int i = 0; i < 5 && i < q_idx.size(); i++) begin
      chk("rr_order", q_idx[i], i % 4);
      if (i > 0) chk("rr_spacing", q_cyc[i] - q_cyc[i-1], 3);
    end
    REQ = '0;

    // reset during WRITE of requester 1 aborts; restart picks lowest bit
    do_reset();
    REQ = 4'b1110;
    step();
    step();
    chk("abort_pre_ack", ACK, 4'b0010);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_we", WE, 0);
    chk("abort_ack", ACK, 0);
    chk("abort_gnt", GNT, 0);
    model_reset();
    REQ = 4'b1100;
    @(negedge CLK);
    RST = 1'b0;
    step();
    chk("abort_regrant", GNT, 4'b0100);
    step();
    step();
    REQ = '0;

    // inputs changed mid-transfer do not disturb the captured write
    do_reset();
    REQ = 4'b0001;
    REQ_ADDR = {5'd0, 5'd0, 5'd0, 5'd7};
    REQ_DATA = {32'h0, 32'h0, 32'h0, 32'h1234_5678};
    step();
    REQ = '0;
    REQ_DATA[31:0] = 32'hFFFF_FFFF;
    step();
    chk("hold_wdata", W_DATA, 32'h1234_5678);
    chk("hold_waddr", W_ADDR, 7);
    step();

`ifdef REG_WRITE_ARB_LOCK_EN
    // locked requester 0 gets back-to-back writes, then requester 1
    begin
      int n0;
      n0 = 0;
      q_idx.delete();
      do_reset();
      LOCK = 4'b0001;
      REQ = 4'b0011;
      for (int c = 0; c < 16; c++) begin
        step();
        if (ACK != '0) q_idx.push_back(ack_idx(ACK));
        if (ACK[0]) begin
          n0++;
          if (n0 == 3) LOCK = '0;
        end
      end
      chk("lock_count", q_idx.size() >= 4, 1);
      for (int i = 0; i < 4 && i < q_idx.size(); i++)
        chk("lock_order", q_idx[i], (i < 3) ? 0 : 1);
      REQ = '0;
    end
`endif

    // randomized traffic: requests mostly held until acknowledged
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int j = 0; j < N; j++) begin
        if (REQ[j] && !ACK[j])
          REQ[j] = ($urandom_range(0, 15) != 0);
        else
          REQ[j] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) begin
          REQ_ADDR[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? '0 :
                                 AW'($urandom_range(0, 31));
          REQ_DATA[j*DW +: DW] = $urandom;
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

endmodule
